// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
//   CPU data-port bus plus the TX byte stream of the data-memory subsystem.
//   master : the CPU/consumer side (drives requests and tx_ready)
//   slave  : the data_mem_ctrl side (returns rd_data and the TX head)
//   Signals:
//     addr[31:0]      byte address
//     wr_data[31:0]   store data, right-aligned
//     memwrite        store request this cycle
//     memread         load request this cycle
//     sign_mask[3:0]  [2:0] size (001 byte, 011 half, 111 word), [3] zero-extend
//     rd_data[31:0]   registered load result
//     tx_data[7:0]    TX FIFO head byte (0 when empty)
//     tx_valid        TX FIFO non-empty
//     tx_ready        consumer accepts the head on tx_valid & tx_ready
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output addr, wr_data, memwrite, memread, sign_mask, tx_ready,
    input  rd_data, tx_data, tx_valid
  );

  modport slave (
    input  addr, wr_data, memwrite, memread, sign_mask, tx_ready,
    output rd_data, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//   Data-memory subsystem on the CPU data port: word-organised RAM with
//   byte-lane stores and sign/zero-extending loads, plus an MMIO window with
//   an LED register, a free-running cycle counter and a TX byte FIFO.
//   Ports:
//     clk           clock
//     rst           synchronous, active-high reset
//     bus           data_mem_ctrl_if.slave (CPU request/response + TX stream)
//     led[7:0]      LED register
//     misalign_err  sticky flag: a misaligned access occurred
//   MMIO map (relative to MMIO_BASE): +0 LED, +4 TX push / status, +8 counter.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int          WORDS      = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_2000
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_ctrl_if.slave   bus,
  output logic [7:0]       led,
  output logic             misalign_err
);

  localparam int          AW       = $clog2(WORDS);
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [29:0] LED_WA   = MMIO_BASE[31:2];
  localparam logic [29:0] TX_WA    = LED_WA + 30'd1;
  localparam logic [29:0] CNT_WA   = LED_WA + 30'd2;
  localparam logic [31:0] RAM_END  = 32'(4 * WORDS);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  size_e       sz;
  logic [1:0]  off;
  logic        misaligned;
  logic        in_ram, hit_led, hit_tx, hit_cnt;
  logic        store_ok;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [AW-1:0] ram_idx;

  assign off      = bus.addr[1:0];
  assign ram_idx  = bus.addr[AW+1:2];
  assign in_ram   = bus.addr < RAM_END;
  assign hit_led  = bus.addr[31:2] == LED_WA;
  assign hit_tx   = bus.addr[31:2] == TX_WA;
  assign hit_cnt  = bus.addr[31:2] == CNT_WA;
  assign store_ok = bus.memwrite && !misaligned;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sz         = SZ_WORD;
    byte_en    = 4'b1111;
    wdata_lane = bus.wr_data;
    case (bus.sign_mask[2:0])
      3'b001:  sz = SZ_BYTE;
      3'b011:  sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    misaligned = (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
    // Replicating the low byte/half puts the store data on every lane; the
    // enable mask then picks the lane(s) at addr[1:0].
    case (sz)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << off;
        wdata_lane = {4{bus.wr_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = 4'b0011 << off;
        wdata_lane = {2{bus.wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // RAM
  // -------------------------------------------------------------------------
  logic [31:0] mem [WORDS];

  // NOTE: the RAM array has no reset; clearing it would prevent mapping onto
  // a memory macro and software never relies on its initial contents.
  always_ff @(posedge clk) begin
    if (!rst && store_ok && in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[ram_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // TX FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          overflow, empty, full, push_req, do_push, pop;

  assign empty    = count == '0;
  assign full     = count == FULL_CNT;
  assign pop      = bus.tx_valid && bus.tx_ready;
  assign push_req = store_ok && hit_tx;
  // A pop in the same cycle frees the slot, so a push on a full FIFO survives.
  assign do_push  = push_req && (!full || pop);

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && do_push) fifo_mem[wr_ptr] <= bus.wr_data[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Load path, LED, counter, error flag
  // -------------------------------------------------------------------------
  logic [31:0] cycle_cnt, ram_word, shifted, load_fmt, load_val;

  assign ram_word = mem[ram_idx];
  assign shifted  = ram_word >> {off, 3'b000};

  always_comb begin
    load_fmt = ram_word;
    case (sz)
      SZ_BYTE: load_fmt = bus.sign_mask[3] ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_fmt = bus.sign_mask[3] ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase

    load_val = 32'h0;
    if (bus.memwrite || misaligned) load_val = 32'h0;
    else if (in_ram)                load_val = load_fmt;
    else if (hit_led)               load_val = {24'h0, led};
    else if (hit_tx)                load_val = {29'h0, overflow, full, empty};
    else if (hit_cnt)               load_val = cycle_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= 32'h0;
      led          <= 8'h00;
      misalign_err <= 1'b0;
      cycle_cnt    <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (bus.memread) bus.rd_data <= load_val;
      if ((bus.memread || bus.memwrite) && misaligned) misalign_err <= 1'b1;
      if (store_ok && hit_led) led <= bus.wr_data[7:0];
    end
  end

endmodule
